sensor_conditioner: RTL

Upstream front end of the irrigation controller. It synchronises and debounces the six raw field inputs: tank level switches H, M and L, temperature T, and soil moisture Us and Ua. It delivers clean, glitch-free levels to the level/moisture decision logic, which generates Ve, Bs, Vs, Al and E. It also flags when the cleaned vector changes and when startup settling is complete.

---
 rtl/sensor_conditioner_pkg.sv | 10 +
 rtl/sensor_conditioner_debounce_channel.sv | 36 +++
 rtl/sensor_conditioner.sv | 53 +++++
 3 files changed

// File: rtl/sensor_conditioner_pkg.sv
// rtl/sensor_conditioner_pkg.sv - shared channel count and field-input bit positions
package sensor_conditioner_pkg;
  localparam int N_CH  = 6;
  localparam int CH_H  = 5;
  localparam int CH_M  = 4;
  localparam int CH_L  = 3;
  localparam int CH_T  = 2;
  localparam int CH_US = 1;
  localparam int CH_UA = 0;
endpackage

// File: rtl/sensor_conditioner_debounce_channel.sv
// rtl/sensor_conditioner_debounce_channel.sv - per-bit synchroniser, stability counter and clean flop
module debounce_channel #(
  parameter int STABLE_SAMPLES = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic clean,
  output logic update
);
  localparam int CW = $clog2(STABLE_SAMPLES + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] count;
  logic          differs;

  assign differs = sync_q[1] != clean;
  // Qualifies on the tick that would complete the run, so count never reaches STABLE_SAMPLES.
  assign update  = tick && differs && (int'(count) + 1 == STABLE_SAMPLES);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      count  <= '0;
      clean  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (tick) begin
        if (!differs || update) count <= '0;
        else                    count <= count + 1'b1;
        if (update) clean <= sync_q[1];
      end
    end
  end
endmodule

// File: rtl/sensor_conditioner.sv
// rtl/sensor_conditioner.sv - debounces the six irrigation field inputs with a shared sample prescaler
module sensor_conditioner
  import sensor_conditioner_pkg::*;
#(
  parameter int SAMPLE_DIV     = 50000,
  parameter int STABLE_SAMPLES = 20
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] clean_out,
  output logic            changed,
  output logic            ready,
  output logic            sample_tick
);
  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SW = $clog2(STABLE_SAMPLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SAMPLE_DIV - 1);

  logic [PW-1:0]   presc;
  logic [SW-1:0]   startup;
  logic [N_CH-1:0] update;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_ch (
      .clock (clock),
      .reset (reset),
      .raw   (raw_in[i]),
      .tick  (sample_tick),
      .clean (clean_out[i]),
      .update(update[i])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc       <= '0;
      sample_tick <= 1'b0;
      startup     <= '0;
      ready       <= 1'b0;
      changed     <= 1'b0;
    end else begin
      presc       <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
      sample_tick <= (presc == PRESC_LAST);
      changed     <= |update;
      // Startup window is measured in sample ticks, matching the channel qualification time.
      if (sample_tick && int'(startup) < STABLE_SAMPLES) begin
        startup <= startup + 1'b1;
        if (int'(startup) + 1 == STABLE_SAMPLES) ready <= 1'b1;
      end
    end
  end
endmodule
